// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Covers the FSM state encoding and the byte-lane geometry of a 32-bit word.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    LOAD,
    DONE,
    ERR
  } state_e;

  localparam int WORD_BYTES = 4;
  localparam int LANE_W     = 2;

  typedef logic [LANE_W-1:0] lane_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words.
// word_valid/word are combinational from the byte that completes a word.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  lane_t       lane_q, lane_d;
  logic [31:0] asm_q, asm_d;

  always_comb begin
    lane_d = lane_q;
    asm_d  = asm_q;
    if (clear) begin
      lane_d = '0;
      asm_d  = '0;
    end else if (byte_en) begin
      // The lane counter wraps from 3 back to 0 on the word-completing byte.
      lane_d                         = lane_q + 1'b1;
      asm_d[{lane_q, 3'b000} +: 8]   = byte_data;
    end
  end

  assign word_valid = byte_en && !clear && (lane_q == lane_t'(WORD_BYTES - 1));
  assign word       = {byte_data, asm_q[23:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_q <= '0;
      asm_q  <= '0;
    end else begin
      lane_q <= lane_d;
      asm_q  <= asm_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory and holds
// the core in reset until the whole program has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              byte_ready_q, byte_ready_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [ADDR_W:0]   words_loaded_q, words_loaded_d;

  logic              byte_en;
  logic              restart;
  logic              word_valid;
  logic [31:0]       word;
  logic [ADDR_W:0]   words_inc;

  function automatic logic len_ok(input logic [31:0] w);
    return (w[31:ADDR_W+1] == '0) && (w[ADDR_W:0] != '0) && (w[ADDR_W:0] <= MAX_WORDS);
  endfunction

  assign byte_en   = byte_valid && byte_ready_q;
  assign restart   = start && (state_q == IDLE || state_q == DONE || state_q == ERR);
  assign words_inc = words_loaded_q + 1'b1;

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (restart),
    .byte_en    (byte_en),
    .byte_data  (byte_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    imem_we_d      = 1'b0;
    imem_addr_d    = imem_addr_q;
    imem_wdata_d   = imem_wdata_q;
    words_loaded_d = words_loaded_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (restart) begin
          state_d        = LEN;
          imem_addr_d    = '0;
          words_loaded_d = '0;
        end
      end
      LEN: begin
        if (word_valid) begin
          if (len_ok(word)) begin
            len_d   = word[ADDR_W:0];
            state_d = LOAD;
          end else begin
            state_d = ERR;
          end
        end
      end
      LOAD: begin
        if (word_valid) begin
          imem_we_d    = 1'b1;
          imem_wdata_d = word;
        end
        // Address advances at the end of the write cycle; after a full-memory
        // load it wraps to 0 without issuing any further write.
        if (imem_we_q) begin
          imem_addr_d    = imem_addr_q + 1'b1;
          words_loaded_d = words_inc;
          if (words_inc == len_q) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    byte_ready_d = (state_d == LEN) || (state_d == LOAD);
    cpu_hold_d   = (state_d != DONE);
    done_d       = (state_d == DONE);
    error_d      = (state_d == ERR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      len_q          <= '0;
      byte_ready_q   <= 1'b0;
      imem_we_q      <= 1'b0;
      imem_addr_q    <= '0;
      imem_wdata_q   <= '0;
      cpu_hold_q     <= 1'b1;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      words_loaded_q <= '0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      byte_ready_q   <= byte_ready_d;
      imem_we_q      <= imem_we_d;
      imem_addr_q    <= imem_addr_d;
      imem_wdata_q   <= imem_wdata_d;
      cpu_hold_q     <= cpu_hold_d;
      done_q         <= done_d;
      error_q        <= error_d;
      words_loaded_q <= words_loaded_d;
    end
  end

  assign byte_ready   = byte_ready_q;
  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: unit 0 uses ADDR_W=8, unit 1 uses ADDR_W=4.
module tb_imem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rstn;
  logic [1:0]       start_s;
  logic [1:0]       valid_s;
  logic [1:0][7:0]  data_s;
  logic [1:0]       ready_s;
  logic [1:0]       we_s;
  logic [1:0]       hold_s;
  logic [1:0]       done_s;
  logic [1:0]       err_s;
  logic [1:0][31:0] wdata_s;
  logic [7:0]       addr0;
  logic [8:0]       wl0;
  logic [3:0]       addr1;
  logic [4:0]       wl1;

  imem_loader #(.ADDR_W(8)) u0 (
    .clk(clk), .reset(rstn[0]), .start(start_s[0]), .byte_valid(valid_s[0]),
    .byte_data(data_s[0]), .byte_ready(ready_s[0]), .imem_we(we_s[0]),
    .imem_addr(addr0), .imem_wdata(wdata_s[0]), .cpu_hold(hold_s[0]),
    .done(done_s[0]), .error(err_s[0]), .words_loaded(wl0)
  );

  imem_loader #(.ADDR_W(4)) u1 (
    .clk(clk), .reset(rstn[1]), .start(start_s[1]), .byte_valid(valid_s[1]),
    .byte_data(data_s[1]), .byte_ready(ready_s[1]), .imem_we(we_s[1]),
    .imem_addr(addr1), .imem_wdata(wdata_s[1]), .cpu_hold(hold_s[1]),
    .done(done_s[1]), .error(err_s[1]), .words_loaded(wl1)
  );

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic int get_addr(input int u);
    return (u == 0) ? int'(addr0) : int'(addr1);
  endfunction

  function automatic int get_wl(input int u);
    return (u == 0) ? int'(wl0) : int'(wl1);
  endfunction

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    #1;
    for (int u = 0; u < 2; u++) begin
      exp_t e;
      logic have;
      have = 1'b0;
      if (we_s[u] === 1'b1) begin
        if (u == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        if (u == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        if (!have) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: unit %0d addr %0d data 0x%08h, required no write",
                   u, get_addr(u), wdata_s[u]);
        end else begin
          check($sformatf("u%0d_waddr", u), get_addr(u), e.addr);
          check($sformatf("u%0d_wdata", u), wdata_s[u], e.data);
          check($sformatf("u%0d_wcycle", u), cyc, e.cyc);
          $display("write u%0d addr=%0d data=0x%08h cycle=%0d", u, get_addr(u), wdata_s[u], cyc);
        end
      end
    end
  end

  // All tasks are entered and left at a falling clock edge.
  task automatic send_byte(input int u, input logic [7:0] b, output int acc_cyc);
    int n;
    valid_s[u] = 1'b1;
    data_s[u]  = b;
    n = 0;
    while (ready_s[u] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (ready_s[u] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: unit %0d byte_ready=%b, required 1", u, ready_s[u]);
      valid_s[u] = 1'b0;
      acc_cyc = -1;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    acc_cyc    = cyc;
    valid_s[u] = 1'b0;
  endtask

  task automatic send_word(input int u, input logic [31:0] w, input bit gaps,
                           input bit is_data, input int addr);
    int   acc;
    exp_t e;
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      if (gaps) repeat ((i + addr) % 3) @(negedge clk);
      b = w[8*i +: 8];
      send_byte(u, b, acc);
    end
    if (is_data) begin
      e.addr = addr;
      e.data = w;
      e.cyc  = acc;
      if (u == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic pulse_start(input int u);
    start_s[u] = 1'b1;
    @(negedge clk);
    start_s[u] = 1'b0;
  endtask

  task automatic check_status(input int u, input string tag, input logic rdy,
                              input logic hold, input logic dn, input logic er, input int wl);
    check($sformatf("u%0d_%s_ready", u, tag), ready_s[u], rdy);
    check($sformatf("u%0d_%s_hold", u, tag), hold_s[u], hold);
    check($sformatf("u%0d_%s_done", u, tag), done_s[u], dn);
    check($sformatf("u%0d_%s_error", u, tag), err_s[u], er);
    check($sformatf("u%0d_%s_words", u, tag), get_wl(u), wl);
  endtask

  task automatic check_reset(input int u, input string tag);
    check_status(u, tag, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    check($sformatf("u%0d_%s_we", u, tag), we_s[u], 1'b0);
    check($sformatf("u%0d_%s_addr", u, tag), get_addr(u), 0);
    check($sformatf("u%0d_%s_wdata", u, tag), wdata_s[u], 32'h0);
  endtask

  localparam logic [31:0] W0 = 32'h0050_0093;
  localparam logic [31:0] W1 = 32'h00A0_0113;
  localparam logic [31:0] W2 = 32'h0020_81B3;

  initial begin
    int acc;
    rstn    = 2'b00;
    start_s = 2'b00;
    valid_s = 2'b00;
    data_s  = '0;
    repeat (3) @(negedge clk);
    check_reset(0, "por");
    check_reset(1, "por");
    rstn = 2'b11;
    @(negedge clk);

    // Three-word load with a start pulse ignored mid-LOAD.
    pulse_start(0);
    check_status(0, "len", 1'b1, 1'b1, 1'b0, 1'b0, 0);
    send_word(0, 32'd3, 1'b0, 1'b0, 0);
    send_word(0, W0, 1'b0, 1'b1, 0);
    send_word(0, W1, 1'b0, 1'b1, 1);
    pulse_start(0);
    check_status(0, "load_start", 1'b1, 1'b1, 1'b0, 1'b0, 2);
    send_word(0, W2, 1'b0, 1'b1, 2);
    repeat (2) @(negedge clk);
    check_status(0, "done3", 1'b0, 1'b0, 1'b1, 1'b0, 3);

    // Restart from DONE, same program with source gaps.
    pulse_start(0);
    check_status(0, "restart", 1'b1, 1'b1, 1'b0, 1'b0, 0);
    check("u0_restart_addr", get_addr(0), 0);
    send_word(0, 32'd3, 1'b1, 1'b0, 0);
    send_word(0, W0, 1'b1, 1'b1, 0);
    send_word(0, W1, 1'b1, 1'b1, 1);
    send_word(0, W2, 1'b1, 1'b1, 2);
    repeat (2) @(negedge clk);
    check_status(0, "gaps_done", 1'b0, 1'b0, 1'b1, 1'b0, 3);

    // Length 0 is rejected at the 4th length byte.
    pulse_start(0);
    send_word(0, 32'd0, 1'b0, 1'b0, 0);
    check_status(0, "len0", 1'b0, 1'b1, 1'b0, 1'b1, 0);
    repeat (3) @(negedge clk);
    check_status(0, "len0_hold", 1'b0, 1'b1, 1'b0, 1'b1, 0);

    // Restart from ERR, then length 257 is rejected.
    pulse_start(0);
    check_status(0, "err_restart", 1'b1, 1'b1, 1'b0, 1'b0, 0);
    send_word(0, 32'd257, 1'b0, 1'b0, 0);
    check_status(0, "len257", 1'b0, 1'b1, 1'b0, 1'b1, 0);
    repeat (3) @(negedge clk);

    // Reset after the 6th data byte, then a fresh one-word load.
    pulse_start(0);
    send_word(0, 32'd3, 1'b0, 1'b0, 0);
    send_word(0, W0, 1'b0, 1'b1, 0);
    send_byte(0, 8'h13, acc);
    send_byte(0, 8'h01, acc);
    rstn[0] = 1'b0;
    #1;
    check_reset(0, "midreset");
    @(negedge clk);
    rstn[0] = 1'b1;
    repeat (2) @(negedge clk);
    pulse_start(0);
    send_word(0, 32'd1, 1'b0, 1'b0, 0);
    send_word(0, 32'h0000_0013, 1'b0, 1'b1, 0);
    repeat (2) @(negedge clk);
    check_status(0, "after_reset", 1'b0, 1'b0, 1'b1, 1'b0, 1);

    // Full memory on the 16-word unit.
    pulse_start(1);
    send_word(1, 32'd16, 1'b0, 1'b0, 0);
    for (int i = 0; i < 16; i++)
      send_word(1, 32'hA000_0000 + 32'(i) * 32'h0001_0101, 1'b0, 1'b1, i);
    repeat (2) @(negedge clk);
    check_status(1, "full", 1'b0, 1'b0, 1'b1, 1'b0, 16);
    check("u1_full_addr_wrap", get_addr(1), 0);

    repeat (3) @(negedge clk);
    check("pending_writes", q0.size() + q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
